// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source edge/level pending capture, mask, and a one-at-a-time REQ/SERVICE handshake.
// Define IRQ_ROUND_ROBIN_EN for rotating priority (start after the last acked source); default is lowest-index-wins.
module irq_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  irq_src,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    output logic              ir_req,
    output logic [ID_W-1:0]   ir_id,
    input  logic              ir_ack,
    input  logic              eret
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state_q;
    logic              ir_req_q;
    logic [ID_W-1:0]   ir_id_q;

    logic [N_SRC-1:0]  src_q;
    logic [N_SRC-1:0]  mask_q, mask_d;
    logic [N_SRC-1:0]  mode_q, mode_d;
    logic [N_SRC-1:0]  pend_q, pend_d;
    logic [N_SRC-1:0]  set_vec, clr_vec;
    logic [N_SRC-1:0]  elig_q, elig_d;
    logic [N_SRC-1:0]  wdata_n;

    logic              wr_mask, wr_pend, wr_mode;
    logic              ack_hit;
    logic              keep_req;
    logic              sel_vld;
    logic [ID_W-1:0]   sel_id;

    assign wdata_n = cfg_wdata[N_SRC-1:0];
    assign wr_mask = cfg_we && (cfg_addr == 2'd0);
    assign wr_pend = cfg_we && (cfg_addr == 2'd1);
    assign wr_mode = cfg_we && (cfg_addr == 2'd2);
    assign ack_hit = (state_q == REQ) && ir_ack;

    generate
        if (N_SRC < 32) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^cfg_wdata[31:N_SRC];
        end
    endgenerate

    // A new set always beats a same-cycle W1C or acknowledge clear.
    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_pend
            assign set_vec[gi] = mode_q[gi] ? irq_src[gi] : (irq_src[gi] & ~src_q[gi]);
            assign clr_vec[gi] = (wr_pend & wdata_n[gi]) |
                                 (ack_hit & (ir_id_q == ID_W'(gi)));
            assign pend_d[gi]  = set_vec[gi] | (pend_q[gi] & ~clr_vec[gi]);
        end
    endgenerate

    assign mask_d = wr_mask ? wdata_n : mask_q;
    assign mode_d = wr_mode ? wdata_n : mode_q;

    assign elig_q   = pend_q & mask_q;
    // Withdrawal looks at next-state eligibility so a mask write or W1C drops ir_req on the edge it lands.
    assign elig_d   = pend_d & mask_d;
    assign keep_req = elig_d[ir_id_q];
    assign sel_vld  = |elig_q;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else if (ack_hit) begin
            rr_ptr_q <= (ir_id_q == ID_W'(N_SRC - 1)) ? '0 : ir_id_q + 1'b1;
        end
    end

    // Scan downward from the farthest offset so the source nearest the pointer is assigned last and wins.
    always_comb begin
        int idx;
        sel_id = '0;
        idx    = 0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (elig_q[idx]) begin
                sel_id = ID_W'(idx);
            end
        end
    end
`else
    always_comb begin
        sel_id = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (elig_q[k]) begin
                sel_id = ID_W'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q  <= '0;
            mask_q <= '0;
            mode_q <= '0;
            pend_q <= '0;
        end else begin
            src_q  <= irq_src;
            mask_q <= mask_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ir_req_q <= 1'b0;
            ir_id_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        ir_id_q  <= sel_id;
                        ir_req_q <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (ir_ack) begin
                        ir_req_q <= 1'b0;
                        state_q  <= SERVICE;
                    end else if (!keep_req) begin
                        ir_req_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                SERVICE: begin
                    if (eret) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ir_req_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign ir_req = ir_req_q;
    assign ir_id  = ir_id_q;

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0: cfg_rdata[N_SRC-1:0] = mask_q;
            2'd1: cfg_rdata[N_SRC-1:0] = pend_q;
            2'd2: cfg_rdata[N_SRC-1:0] = mode_q;
            default: begin
                cfg_rdata[9:8]      = state_q;
                cfg_rdata[ID_W-1:0] = ir_id_q;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expectations, a negedge monitor checks them and every ir_req rise.
// Build with IRQ_ROUND_ROBIN_EN defined to also exercise the rotating-priority sequence.
module tb_irq_ctrl;

    localparam int N = 8;
    localparam int W = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq_src;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [31:0]   cfg_wdata;
    logic [31:0]   cfg_rdata;
    logic          ir_req;
    logic [W-1:0]  ir_id;
    logic          ir_ack;
    logic          eret;

    always #5 clk = ~clk;

    irq_ctrl #(.N_SRC(N), .ID_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .ir_req    (ir_req),
        .ir_id     (ir_id),
        .ir_ack    (ir_ack),
        .eret      (eret)
    );

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t cq[$];
    int   rq[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_req = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int sel, input logic [31:0] exp, input string name);
        chk_t c;
        c.sel  = sel;
        c.exp  = exp;
        c.name = name;
        cq.push_back(c);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        cfg_addr = a;
        chk(0, exp, name);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic expect_req(input int id);
        rq.push_back(id);
    endtask

    // sel 0: cfg_rdata, 1: ir_req, 2: ir_id
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        int          e;
        while (cq.size() > 0) begin
            c = cq.pop_front();
            if (c.sel == 0)      act = cfg_rdata;
            else if (c.sel == 1) act = {31'b0, ir_req};
            else                 act = {{(32-W){1'b0}}, ir_id};
            total++;
            if (act !== c.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", c.name, act, c.exp);
            end else begin
                $display("ok   %s: %h", c.name, act);
            end
        end
        if (ir_req === 1'b1 && prev_req !== 1'b1) begin
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL req_rise: got unexpected request id=%0d want none", ir_id);
            end else begin
                e = rq.pop_front();
                if (int'(ir_id) != e) begin
                    bad++;
                    $display("FAIL req_rise: got id=%0d want id=%0d", ir_id, e);
                end else begin
                    $display("ok   req_rise: id=%0d", ir_id);
                end
            end
        end
        prev_req = ir_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ids[4];
        rst = 1'b0; irq_src = '0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        ir_ack = 1'b0; eret = 1'b0;
        tick(); tick();
        rst = 1'b1;

        // reset state
        rd(0, 32'h0, "rst_mask"); chk(1, 0, "rst_req"); chk(2, 0, "rst_id"); tick();
        rd(1, 32'h0, "rst_pend"); tick();
        rd(2, 32'h0, "rst_mode"); tick();
        rd(3, 32'h0, "rst_status"); tick();
        wr(0, 32'h0000_00FF);

        // single edge source, 2-cycle latency, ack, eret
        irq_src = 8'h08; expect_req(3); tick();
        irq_src = 8'h00; chk(1, 0, "a_lat1"); tick();
        chk(1, 1, "a_req"); chk(2, 3, "a_id"); rd(3, 32'h103, "a_status_req"); tick();
        ir_ack = 1'b1; tick();
        ir_ack = 1'b0; chk(1, 0, "a_req_ack"); rd(1, 32'h0, "a_pend"); tick();
        rd(3, 32'h203, "a_status_svc"); tick();
        eret = 1'b1; tick();
        eret = 1'b0; rd(3, 32'h003, "a_status_idle"); tick();

        // two simultaneous edges, fixed priority
        irq_src = 8'h24; expect_req(2); tick();
        irq_src = 8'h00; tick();
        chk(2, 2, "b_id2");
        ir_ack = 1'b1; tick();
        ir_ack = 1'b0; rd(1, 32'h20, "b_pend5"); tick();
        eret = 1'b1; tick();
        eret = 1'b0; expect_req(5); chk(1, 0, "b_idle_noreq"); rd(3, 32'h002, "b_status_idle"); tick();
        chk(1, 1, "b_req5"); chk(2, 5, "b_id5");
        ir_ack = 1'b1; tick();
        ir_ack = 1'b0; eret = 1'b1; tick();
        eret = 1'b0; tick();

        // withdrawal by mask, then re-request
        irq_src = 8'h10; expect_req(4); tick();
        irq_src = 8'h00; tick();
        chk(1, 1, "c_req4");
        wr(0, 32'h0000_00EF);
        chk(1, 0, "c_withdrawn"); rd(3, 32'h004, "c_status_idle"); tick();
        rd(1, 32'h10, "c_pend4"); tick();
        expect_req(4);
        wr(0, 32'h0000_00FF);
        tick();
        chk(1, 1, "c_rereq"); chk(2, 4, "c_id4");
        ir_ack = 1'b1; tick();
        ir_ack = 1'b0; eret = 1'b1; tick();
        eret = 1'b0;

        // new source during service; W1C vs set; W1C withdrawal
        irq_src = 8'h02; expect_req(1); tick();
        irq_src = 8'h00; tick();
        ir_ack = 1'b1; tick();
        ir_ack = 1'b0; irq_src = 8'h01; tick();
        irq_src = 8'h00; chk(1, 0, "d_svc_noreq"); rd(1, 32'h01, "d_pend0"); tick();
        eret = 1'b1; expect_req(0); tick();
        eret = 1'b0; tick();
        chk(1, 1, "d_req0"); chk(2, 0, "d_id0");
        irq_src = 8'h01;
        wr(1, 32'h01);
        irq_src = 8'h00; chk(1, 1, "d_still_req"); rd(1, 32'h01, "d_pend_setwins"); tick();
        wr(1, 32'h01);
        chk(1, 0, "d_w1c_withdraw"); rd(3, 32'h000, "d_status"); tick();

        // ack-clear vs set; eret ignored in REQ
        irq_src = 8'h40; expect_req(6); tick();
        irq_src = 8'h00; tick();
        ir_ack = 1'b1; irq_src = 8'h40; tick();
        ir_ack = 1'b0; irq_src = 8'h00; rd(1, 32'h40, "e_ack_set"); chk(1, 0, "e_svc"); tick();
        rd(3, 32'h206, "e_status_svc"); tick();
        eret = 1'b1; expect_req(6); tick();
        eret = 1'b0; tick();
        chk(2, 6, "e_id6");
        eret = 1'b1; tick();
        eret = 1'b0; chk(1, 1, "e_eret_ignored"); rd(3, 32'h106, "e_status_req"); tick();

        // asynchronous reset mid-REQ
        #2;
        rst = 1'b0; chk(1, 0, "f_async_req"); chk(2, 0, "f_async_id");
        tick();
        rst = 1'b1;
        rd(0, 32'h0, "f_mask"); tick();
        rd(1, 32'h0, "f_pend"); tick();
        rd(2, 32'h0, "f_mode"); tick();
        rd(3, 32'h0, "f_status"); tick();
        tick();
        chk(1, 0, "f_no_req_after"); tick();

        // level mode
        wr(2, 32'h02);
        wr(0, 32'hFF);
        irq_src = 8'h02; expect_req(1); tick();
        tick();
        chk(2, 1, "g_id1");
        ir_ack = 1'b1; tick();
        ir_ack = 1'b0; rd(1, 32'h02, "g_level_pend"); tick();
        eret = 1'b1; expect_req(1); tick();
        eret = 1'b0; tick();
        chk(1, 1, "g_rereq");
        ir_ack = 1'b1; tick();
        ir_ack = 1'b0; irq_src = 8'h00;
        wr(1, 32'h02);
        eret = 1'b1; tick();
        eret = 1'b0; tick();
        chk(1, 0, "g_no_req"); rd(1, 32'h0, "g_pend_clr"); tick();

`ifdef IRQ_ROUND_ROBIN_EN
        // rotating priority between two held level sources
        rst = 1'b0; tick();
        rst = 1'b1;
        wr(0, 32'hFF);
        wr(2, 32'h42);
        ids[0] = 1; ids[1] = 6; ids[2] = 1; ids[3] = 6;
        irq_src = 8'h42; expect_req(ids[0]); tick();
        tick();
        chk(2, ids[0], "rr_id0");
        for (int i = 1; i < 4; i++) begin
            ir_ack = 1'b1; tick();
            ir_ack = 1'b0; eret = 1'b1; expect_req(ids[i]); tick();
            eret = 1'b0; tick();
            chk(2, 32'(ids[i]), "rr_id");
        end
        ir_ack = 1'b1; tick();
        ir_ack = 1'b0; irq_src = 8'h00;
        wr(1, 32'h42);
        eret = 1'b1; tick();
        eret = 1'b0; tick();
        chk(1, 0, "rr_done"); tick();
`else
        ids[0] = 0;
`endif

        tick();
        @(negedge clk);
        #1;
        total++;
        if (rq.size() != 0 || cq.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d requests %0d checks outstanding want 0", rq.size(), cq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
